timer_controller: RTL
=====================

Name: timer_controller

Overview:
- Memory-mapped programmable timer peripheral on one device slot of the I/O select logic, alongside the LED and UART controllers.
- Uses the same device bus: we, reg_sel, 16-bit write data in, 16-bit read data out, and the cs strobe.
- Provides a prescaled up-counter with compare limit, one-shot or auto-reload mode, and a sticky DONE flag that the CPU polls.
- DONE is also exported as a level output, e.g. for an LED.

Parameters:
- PRESCALE_RST, 16'd0, reset value of the PRESCALE register.
- LIMIT_RST, 16'hFFFF, reset value of the LIMIT register.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- cs  input  1  device select from the I/O select logic.
- we  input  1  write enable; a write occurs only when cs=1 and we=1.
- reg_sel  input  2  register index.
- in  input  16  write data.
- out  output  16  read data for the register selected by reg_sel; combinational, independent of cs.
- done  output  1  copy of the DONE flag.

Behaviour:
- Register map, write (cs & we):
  - 0 CTRL: bit0 EN, bit1 AUTO; bit15=1 clears DONE; other bits ignored.
  - 1 PRESCALE.
  - 2 LIMIT.
  - 3 COUNT: loads the counter.
- Register map, read:
  - 0 {DONE, 13'b0, AUTO, EN}.
  - 1 PRESCALE.
  - 2 LIMIT.
  - 3 COUNT.
- Reset (reset=0 at an edge): EN=0, AUTO=0, DONE=0, COUNT=0, prescale counter PC=0, PRESCALE=PRESCALE_RST, LIMIT=LIMIT_RST. Therefore done=0 and out=16'h0000 when reg_sel=0.
- Reset mid-count aborts immediately. No tick or DONE is produced on the reset edge.
- States:
  - STOPPED (EN=0): PC and COUNT hold.
  - RUNNING (EN=1): PC increments each clk.
- Tick: when PC==PRESCALE in RUNNING, PC<=0 and a one-cycle internal tick is asserted. The tick period is PRESCALE+1 clocks; PRESCALE=0 ticks every clock.
- On tick with COUNT!=LIMIT: COUNT<=COUNT+1.
- On tick with COUNT==LIMIT: DONE<=1, then:
  - AUTO=1: COUNT<=0, stay RUNNING.
  - AUTO=0: COUNT holds, EN<=0 (return to STOPPED).
- First DONE after starting from COUNT=0, PC=0: (LIMIT+1)*(PRESCALE+1) clocks after the edge that sets EN.
- LIMIT=0: DONE on every tick.
- COUNT>LIMIT (loaded by write or LIMIT lowered): COUNT keeps incrementing, wraps 16'hFFFF→0, then reaches LIMIT. No special casing.
- Write side effects:
  - CTRL write taking EN 0→1 clears PC to 0.
  - PRESCALE write clears PC to 0.
  - COUNT write clears PC to 0.
  - LIMIT write does not disturb PC or COUNT.
- Write/count collision in the same cycle: the CPU write wins for the written register.
  - COUNT write overrides the tick increment.
  - CTRL write of EN overrides the one-shot auto-clear of EN.
- DONE set (expiry) and DONE clear (CTRL bit15) in the same cycle: set wins; the event is never lost.
- Writes with cs=0 or we=0 have no effect. Reads have no side effects.
- Latency: a written value is visible on out the cycle after the write edge.

Test Plan:
- Reset then read: hold reset=0 for 2 clocks, release; read reg 0,1,2,3 → 16'h0000, 16'h0000, 16'hFFFF, 16'h0000; done=0.
- One-shot: PRESCALE=3, LIMIT=4, CTRL=16'h0001 → done rises exactly 20 clocks after the CTRL write edge; then CTRL reads 16'h8000 (EN=0, DONE=1), COUNT=4 and stays 4 for a further 50 clocks.
- Auto-reload: PRESCALE=0, LIMIT=2, CTRL=16'h0003 → COUNT sequence 0,1,2,0,1,2… one step per clock; DONE set at clock 3; write CTRL=16'h8003 → DONE clears and is set again within 3 clocks.
- Collision: arrange expiry on the same edge as a CTRL=16'h8003 write → DONE reads 1 afterwards. Also write COUNT=16'h0010 on a tick edge → COUNT reads 16'h0010, not an incremented value.
- Wrap / cs gating: LIMIT=1, COUNT=16'hFFFE, PRESCALE=0, AUTO=0, EN=1 → COUNT goes FFFF, 0, 1; DONE at the tick where COUNT==1. Writes with cs=0 to every register leave all readback values unchanged.
- Reset mid-operation: RUNNING with COUNT=5 and DONE=1, assert reset=0 for 1 clock → all registers return to their reset values, done=0, no further ticks until re-enabled.

Source files
------------

// File: rtl/timer_controller.sv
// Memory-mapped prescaled timer: up-counter with compare limit, one-shot or
// auto-reload, and a sticky DONE flag that the CPU polls.
module timer_controller #(
  parameter logic [15:0] PRESCALE_RST = 16'd0,
  parameter logic [15:0] LIMIT_RST    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        done
);

  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESCALE = 2'd1;
  localparam logic [1:0] REG_LIMIT    = 2'd2;
  localparam logic [1:0] REG_COUNT    = 2'd3;

  // EN bit of CTRL is the run state itself.
  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                auto_q, auto_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   prescale_q, prescale_d;
  logic [DATA_W-1:0]   limit_q, limit_d;

  logic                wr_c;
  logic                tick_c;
  logic                done_set_c;
  logic                done_clr_c;

  // State and register file; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= STOPPED;
      auto_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      pc_q       <= '0;
      prescale_q <= PRESCALE_RST;
      limit_q    <= LIMIT_RST;
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      done_q     <= done_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      prescale_q <= prescale_d;
      limit_q    <= limit_d;
    end
  end

  // Next state: count/tick first, then CPU writes override the written register.
  always_comb begin
    state_d    = state_q;
    auto_d     = auto_q;
    count_d    = count_q;
    pc_d       = pc_q;
    prescale_d = prescale_q;
    limit_d    = limit_q;
    tick_c     = 1'b0;
    done_set_c = 1'b0;
    done_clr_c = 1'b0;
    wr_c       = cs & we;

    case (state_q)
      RUNNING: begin
        if (pc_q == prescale_q) begin
          pc_d   = '0;
          tick_c = 1'b1;
        end else begin
          pc_d = pc_q + DATA_W'(1);
        end
      end
      default: begin
      end
    endcase

    if (tick_c) begin
      if (count_q != limit_q) begin
        count_d = count_q + DATA_W'(1);
      end else begin
        done_set_c = 1'b1;
        if (auto_q) begin
          count_d = '0;
        end else begin
          state_d = STOPPED;
        end
      end
    end

    if (wr_c) begin
      case (reg_sel)
        REG_CTRL: begin
          state_d    = in[0] ? RUNNING : STOPPED;
          auto_d     = in[1];
          done_clr_c = in[15];
          // Starting from stopped restarts the prescaler phase.
          if (in[0] && (state_q == STOPPED)) begin
            pc_d = '0;
          end
        end
        REG_PRESCALE: begin
          prescale_d = in;
          pc_d       = '0;
        end
        REG_LIMIT: begin
          limit_d = in;
        end
        default: begin
          count_d = in;
          pc_d    = '0;
        end
      endcase
    end

    // An expiry in the same cycle as a clear must not be lost.
    done_d = (done_q & ~done_clr_c) | done_set_c;
  end

  // Read mux, combinational and independent of cs.
  always_comb begin
    out = '0;
    case (reg_sel)
      REG_CTRL:     out = {done_q, 13'b0, auto_q, state_q == RUNNING};
      REG_PRESCALE: out = prescale_q;
      REG_LIMIT:    out = limit_q;
      default:      out = count_q;
    endcase
  end

  assign done = done_q;

endmodule
